// File: rtl/control_unit_pkg.sv
// Shared encodings for the PhilosophyV multi-cycle control unit:
// state codes, datapath select encodings, trap causes and RV32 opcodes.
package control_unit_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE         = 2'd0,
    CAUSE_ILLEGAL      = 2'd1,
    CAUSE_IMEM_TIMEOUT = 2'd2,
    CAUSE_DMEM_TIMEOUT = 2'd3
  } trap_cause_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic PC_SEL_PC4 = 1'b0;
  localparam logic PC_SEL_ALU = 1'b1;
  localparam logic ALU_A_RS1  = 1'b0;
  localparam logic ALU_A_PC   = 1'b1;
  localparam logic ALU_B_RS2  = 1'b0;
  localparam logic ALU_B_IMM  = 1'b1;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;

  // Every strobe the sequencer drives, gathered so one default covers them all.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       alu_out_write;
    logic       control_override;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic       pc_sel;
  } ctl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_ALU_REG) || (op == OP_ALU_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE)   || (op == OP_JAL)     || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Memory-handshake wait counter; expired flags the last cycle a request
// may go unanswered before the sequencer traps.
module ctrl_wait_counter #(
  parameter int MEM_TIMEOUT   = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory
// timeout supervision and an illegal-opcode trap.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             opcode,
  input  logic                   imem_ack,
  input  logic                   dmem_ack,
  output logic                   imem_req,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic                   ir_write,
  output logic                   alu_out_write,
  output logic                   control_override,
  output logic                   alu_src_a,
  output logic                   alu_src_b,
  output logic                   reg_write,
  output logic [1:0]             wb_sel,
  output logic                   pc_write,
  output logic                   pc_sel,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [STATE_WIDTH-1:0] state
);

  // Handshake: a request strobe stays high for as long as the FSM sits in its
  // request state; a single-cycle ack in that state completes the transfer.
  // Acks seen in any other state are ignored.

  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;
  ctl_t        ctl;
  logic        waiting, ack_now, expired;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign ack_now = ((state_q == ST_FETCH) && imem_ack) ||
                   ((state_q == ST_MEMORY) && dmem_ack);

  ctrl_wait_counter #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!waiting),
    .enable (waiting && !ack_now),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ctl     = '0;
    unique case (state_q)
      ST_FETCH: begin
        ctl.imem_req = 1'b1;
        if (imem_ack) begin
          ctl.ir_write = 1'b1;
          state_d      = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (is_supported(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        ctl.alu_out_write = 1'b1;
        case (opcode)
          OP_ALU_REG: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_RS2;
          end
          OP_ALU_IMM: begin
            ctl.alu_src_a = ALU_A_RS1;
            ctl.alu_src_b = ALU_B_IMM;
          end
          OP_JAL: begin
            ctl.alu_src_a        = ALU_A_PC;
            ctl.alu_src_b        = ALU_B_IMM;
            ctl.control_override = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctl.alu_src_a        = ALU_A_RS1;
            ctl.alu_src_b        = ALU_B_IMM;
            ctl.control_override = 1'b1;
          end
          default: ;
        endcase
        state_d = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? ST_MEMORY
                                                                : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          state_d = ST_WRITEBACK;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        ctl.pc_write  = 1'b1;
        ctl.reg_write = (opcode != OP_STORE);
        if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          ctl.wb_sel = WB_PC4;
          ctl.pc_sel = PC_SEL_ALU;
        end else begin
          ctl.wb_sel = (opcode == OP_LOAD) ? WB_LOAD : WB_ALU;
          ctl.pc_sel = PC_SEL_PC4;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: ;
      default: begin
        state_d = ST_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Outputs are forced low combinationally while reset is held so the core
  // is quiet even before the first reset edge lands.
  assign imem_req         = rst_n & ctl.imem_req;
  assign dmem_req         = rst_n & ctl.dmem_req;
  assign dmem_we          = rst_n & ctl.dmem_we;
  assign ir_write         = rst_n & ctl.ir_write;
  assign alu_out_write    = rst_n & ctl.alu_out_write;
  assign control_override = rst_n & ctl.control_override;
  assign alu_src_a        = rst_n & ctl.alu_src_a;
  assign alu_src_b        = rst_n & ctl.alu_src_b;
  assign reg_write        = rst_n & ctl.reg_write;
  assign wb_sel           = rst_n ? ctl.wb_sel : 2'd0;
  assign pc_write         = rst_n & ctl.pc_write;
  assign pc_sel           = rst_n & ctl.pc_sel;
  assign trap             = rst_n & (state_q == ST_TRAP);
  assign trap_cause       = rst_n ? cause_q : 2'd0;
  assign state            = rst_n ? state_q : '0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a short memory timeout so the
// timeout and ack-at-limit boundaries are reachable in a few cycles.
module tb_control_unit;

  localparam int TO = 4;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_write, alu_out_write;
  logic       control_override, alu_src_a, alu_src_b, reg_write;
  logic [1:0] wb_sel;
  logic       pc_write, pc_sel, trap;
  logic [1:0] trap_cause;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit #(.MEM_TIMEOUT(TO), .TIMEOUT_WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .imem_ack        (imem_ack),
    .dmem_ack        (dmem_ack),
    .imem_req        (imem_req),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .ir_write        (ir_write),
    .alu_out_write   (alu_out_write),
    .control_override(control_override),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .reg_write       (reg_write),
    .wb_sel          (wb_sel),
    .pc_write        (pc_write),
    .pc_sel          (pc_sel),
    .trap            (trap),
    .trap_cause      (trap_cause),
    .state           (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1-2 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH, acking after iw/dw wait
  // cycles and checking the per-state strobes against the given expectations.
  task automatic run_instr(input string name, input logic [6:0] op,
                           input int iw, input int dw,
                           input logic a, input logic b, input logic ovr,
                           input logic we, input logic rw, input logic [1:0] wb,
                           input logic ps, input int exp_cycles);
    int   cyc = 0;
    int   fw  = 0;
    int   mw  = 0;
    int   pcw = 0;
    logic done = 1'b0;
    opcode = op;
    while (!done && cyc < 40) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      case (state)
        3'd0: begin
          imem_ack = (fw == iw);
          fw++;
          #1;
          chk({name, ".imem_req"}, imem_req, 1);
          chk({name, ".ir_write"}, ir_write, imem_ack);
        end
        3'd2: begin
          #1;
          chk({name, ".alu_out_write"}, alu_out_write, 1);
          chk({name, ".alu_src_a"}, alu_src_a, a);
          chk({name, ".alu_src_b"}, alu_src_b, b);
          chk({name, ".override"}, control_override, ovr);
        end
        3'd3: begin
          dmem_ack = (mw == dw);
          mw++;
          #1;
          chk({name, ".dmem_req"}, dmem_req, 1);
          chk({name, ".dmem_we"}, dmem_we, we);
        end
        3'd4: begin
          #1;
          chk({name, ".reg_write"}, reg_write, rw);
          chk({name, ".wb_sel"}, wb_sel, wb);
          chk({name, ".pc_sel"}, pc_sel, ps);
          done = 1'b1;
        end
        default: #1;
      endcase
      pcw += int'(pc_write);
      cycle();
      cyc++;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk({name, ".cycles"}, cyc, exp_cycles);
    chk({name, ".pc_write_pulses"}, pcw, 1);
    chk({name, ".back_to_fetch"}, state, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = OP_ALU_REG;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    // Reset: everything quiet while held.
    cycle();
    chk("rst.state", state, 0);
    chk("rst.imem_req", imem_req, 0);
    chk("rst.trap", trap, 0);
    chk("rst.pc_write", pc_write, 0);
    chk("rst.trap_cause", trap_cause, 0);
    rst_n = 1'b1;
    #1;
    chk("rel.state", state, 0);
    chk("rel.imem_req", imem_req, 1);

    //        name       op          iw dw  a  b  ov we rw wb    ps cycles
    run_instr("alu_reg", OP_ALU_REG, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 4);
    run_instr("alu_imm", OP_ALU_IMM, 3, 0, 0, 1, 0, 0, 1, 2'd0, 0, 7);
    run_instr("load",    OP_LOAD,    0, 3, 0, 1, 1, 0, 1, 2'd1, 0, 8);
    run_instr("store",   OP_STORE,   0, 2, 0, 1, 1, 1, 0, 2'd0, 0, 7);
    run_instr("jal",     OP_JAL,     0, 0, 1, 1, 1, 0, 1, 2'd2, 1, 4);
    run_instr("jalr",    OP_JALR,    1, 0, 0, 1, 1, 0, 1, 2'd2, 1, 5);

    // imem never acks: four FETCH cycles, then TRAP with cause 2.
    for (int i = 0; i < TO; i++) begin
      chk("ito.fetch", state, 0);
      cycle();
    end
    chk("ito.state", state, 5);
    chk("ito.trap", trap, 1);
    chk("ito.cause", trap_cause, 2);
    chk("ito.imem_req", imem_req, 0);
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    chk("ito.held", state, 5);

    // Reset while in TRAP.
    rst_n = 1'b0;
    #1;
    chk("trst.trap", trap, 0);
    chk("trst.state", state, 0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("trst.fetch", state, 0);
    chk("trst.cause", trap_cause, 0);
    chk("trst.imem_req", imem_req, 1);

    // Illegal opcode traps from DECODE and stays for 20 cycles.
    opcode   = OP_BRANCH;
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    chk("ill.decode", state, 1);
    cycle();
    chk("ill.state", state, 5);
    chk("ill.cause", trap_cause, 1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      cycle();
      chk("ill.stay", {trap, state, pc_write, dmem_req, imem_req}, {1'b1, 3'd5, 3'b000});
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    do_reset();

    // dmem never acks on a LOAD: TRAP with cause 3, no pc_write.
    opcode   = OP_LOAD;
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < TO; i++) begin
      chk("dto.memory", state, 3);
      chk("dto.pc_write", pc_write, 0);
      cycle();
    end
    chk("dto.state", state, 5);
    chk("dto.cause", trap_cause, 3);
    do_reset();

    // Reset mid-MEMORY abandons the data request; stale ack is ignored.
    opcode   = OP_LOAD;
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    cycle();
    cycle();
    chk("mrst.in_memory", state, 3);
    chk("mrst.dmem_req_before", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.quiet", dmem_req, 0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("mrst.state", state, 0);
    chk("mrst.dmem_req", dmem_req, 0);
    chk("mrst.cause", trap_cause, 0);
    dmem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("mrst.stale_ack", state, 0);
    end
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
